// File: rtl/counter_mod_ud.sv
// Modulo up/down counter with a runtime terminal value, load/clear, and carry/borrow for chaining.
// Optional saturating mode is enabled by defining COUNTER_SAT_EN.
module counter_mod_ud #(
  parameter int unsigned W       = 8,
  parameter int unsigned TOP_RST = 59,
  parameter int unsigned CNT_RST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         top_wr,
  input  logic [W-1:0] top_val,
`ifdef COUNTER_SAT_EN
  input  logic         sat,
`endif
  output logic [W-1:0] cnt,
  output logic [W-1:0] top,
  output logic         tc,
  output logic         co,
  output logic         bo
);

  logic         sat_c;
  logic         at_top_c;
  logic         at_zero_c;
  logic [W-1:0] ld_clamp_c;
  logic [W-1:0] cnt_nxt_c;

`ifdef COUNTER_SAT_EN
  assign sat_c = sat;
`else
  assign sat_c = 1'b0;
`endif

  // cnt may sit above top after a top write; treat that as "at top" for up steps
  assign at_top_c   = (cnt >= top);
  assign at_zero_c  = (cnt == '0);
  assign ld_clamp_c = (ld_val > top) ? top : ld_val;

  assign tc = up ? at_top_c : at_zero_c;
  assign co = en &  up & ~clr & ~ld & at_top_c  & ~sat_c;
  assign bo = en & ~up & ~clr & ~ld & at_zero_c & ~sat_c;

  // Next count: clear beats load beats counting
  always_comb begin
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = '0;
    end else if (ld) begin
      cnt_nxt_c = ld_clamp_c;
    end else if (en) begin
      if (up) begin
        if (at_top_c) begin
          cnt_nxt_c = sat_c ? cnt : '0;
        end else begin
          cnt_nxt_c = cnt + W'(1);
        end
      end else begin
        if (at_zero_c) begin
          cnt_nxt_c = sat_c ? cnt : top;
        end else if (cnt > top) begin
          cnt_nxt_c = top;
        end else begin
          cnt_nxt_c = cnt - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= W'(CNT_RST);
      top <= W'(TOP_RST);
    end else begin
      cnt <= cnt_nxt_c;
      if (top_wr) begin
        top <= top_val;
      end
    end
  end

endmodule
